// File: rtl/prf_read_stage.sv
// ----------------------------------------------------------------------------
// prf_read_stage
//
// RF stage of the backend. This block holds the physical register file (PRF).
// It reads both source operands for every lane leaving the IS->RF register and
// registers them into the RF->EX boundary, so the read latency is one cycle.
//
// A writeback in the same cycle is bypassed straight to the read. Physical
// register 0 always reads as zero and is never written.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-low reset
//   clear        flush the RF->EX boundary (mispredict / exception)
//   stall        hold the RF->EX boundary
//   rf_valid     per-lane valid from IS->RF (INT lanes first, then MEM lanes)
//   rf_rs1       per-lane source-1 physical register, PREG_W bits per lane
//   rf_rs2       per-lane source-2 physical register, PREG_W bits per lane
//   wb_valid     per-port writeback enable
//   wb_rd        per-port destination physical register
//   wb_data      per-port result, XLEN bits per port
//   ex_valid     registered lane valid to EX
//   ex_rs1_data  registered source-1 operand per lane
//   ex_rs2_data  registered source-2 operand per lane
// ----------------------------------------------------------------------------
module prf_read_stage #(
    parameter  int PRF_SIZE = 64,
    parameter  int XLEN     = 32,
    parameter  int RD_LANES = 3,
    parameter  int WB_PORTS = 3,
    localparam int PREG_W   = $clog2(PRF_SIZE)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       stall,
    input  logic [RD_LANES-1:0]        rf_valid,
    input  logic [RD_LANES*PREG_W-1:0] rf_rs1,
    input  logic [RD_LANES*PREG_W-1:0] rf_rs2,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0] wb_rd,
    input  logic [WB_PORTS*XLEN-1:0]   wb_data,
    output logic [RD_LANES-1:0]        ex_valid,
    output logic [RD_LANES*XLEN-1:0]   ex_rs1_data,
    output logic [RD_LANES*XLEN-1:0]   ex_rs2_data
);

    // ------------------------------------------------------------------------
    // Register file array
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] prf_q [PRF_SIZE];

    // NOTE: the whole array sits on the asynchronous reset. That keeps it in
    // flops rather than a RAM macro. This is intended: the array must read as
    // zero straight after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PRF_SIZE; i++) begin
                prf_q[i] <= '0;
            end
        end else begin
            // Ports are visited in ascending order and the last non-blocking
            // assignment wins. On a conflict, the highest-index port's data
            // therefore lands.
            for (int w = 0; w < WB_PORTS; w++) begin
                if (wb_valid[w] && (wb_rd[w*PREG_W +: PREG_W] != '0)) begin
                    prf_q[wb_rd[w*PREG_W +: PREG_W]] <= wb_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Operand read with writeback bypass
    // ------------------------------------------------------------------------
    // Start from the array value. Any writeback to the same register this
    // cycle overrides it, and the highest-index port takes precedence, which
    // matches the write priority. Register 0 is forced to zero last.
    function automatic logic [XLEN-1:0] read_operand(
        input logic [PREG_W-1:0]          src,
        input logic [XLEN-1:0]            arr_val,
        input logic [WB_PORTS-1:0]        wv,
        input logic [WB_PORTS*PREG_W-1:0] wrd,
        input logic [WB_PORTS*XLEN-1:0]   wdata
    );
        logic [XLEN-1:0] r;
        r = arr_val;
        for (int w = 0; w < WB_PORTS; w++) begin
            if (wv[w] && (wrd[w*PREG_W +: PREG_W] == src)) begin
                r = wdata[w*XLEN +: XLEN];
            end
        end
        if (src == '0) begin
            r = '0;
        end
        return r;
    endfunction

    logic [XLEN-1:0] rs1_val [RD_LANES];
    logic [XLEN-1:0] rs2_val [RD_LANES];

    always_comb begin
        for (int l = 0; l < RD_LANES; l++) begin
            rs1_val[l] = read_operand(rf_rs1[l*PREG_W +: PREG_W],
                                      prf_q[rf_rs1[l*PREG_W +: PREG_W]],
                                      wb_valid, wb_rd, wb_data);
            rs2_val[l] = read_operand(rf_rs2[l*PREG_W +: PREG_W],
                                      prf_q[rf_rs2[l*PREG_W +: PREG_W]],
                                      wb_valid, wb_rd, wb_data);
        end
    end

    // ------------------------------------------------------------------------
    // RF->EX boundary register
    // ------------------------------------------------------------------------
    logic [RD_LANES-1:0]      ex_valid_q, ex_valid_d;
    logic [RD_LANES*XLEN-1:0] ex_rs1_q,   ex_rs1_d;
    logic [RD_LANES*XLEN-1:0] ex_rs2_q,   ex_rs2_d;

    // Priority is clear > stall > load. A stalled boundary is not refreshed
    // from the array. Issue only sends ready operands, so held values stay
    // correct even when writebacks land meanwhile.
    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through this block can leave one unassigned and infer a latch.
        ex_valid_d = ex_valid_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        if (clear) begin
            ex_valid_d = '0;
            ex_rs1_d   = '0;
            ex_rs2_d   = '0;
        end else if (!stall) begin
            ex_valid_d = rf_valid;
            for (int l = 0; l < RD_LANES; l++) begin
                ex_rs1_d[l*XLEN +: XLEN] = rf_valid[l] ? rs1_val[l] : '0;
                ex_rs2_d[l*XLEN +: XLEN] = rf_valid[l] ? rs2_val[l] : '0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments. All flops then
    // update together at the edge, whatever the order in which the blocks are
    // evaluated.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_rs1_data = ex_rs1_q;
    assign ex_rs2_data = ex_rs2_q;

    // ------------------------------------------------------------------------
    // Simulation-only check
    // ------------------------------------------------------------------------
    // Renaming never gives two in-flight writers the same destination. Flag a
    // conflict if one appears; the write itself still resolves to the
    // highest-index port.
    always @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < WB_PORTS; a++) begin
                for (int b = a + 1; b < WB_PORTS; b++) begin
                    assert (!(wb_valid[a] && wb_valid[b] &&
                              (wb_rd[a*PREG_W +: PREG_W] == wb_rd[b*PREG_W +: PREG_W]) &&
                              (wb_rd[a*PREG_W +: PREG_W] != '0)))
                    else $warning("prf_read_stage: write conflict on preg %0d (ports %0d and %0d)",
                                  wb_rd[a*PREG_W +: PREG_W], a, b);
                end
            end
        end
    end

endmodule
